matrix_frame_source: RTL
========================

Name: matrix_frame_source

Overview:
- Upstream feeder for the 8x8 LED matrix scan controller; supplies its 64-bit frame input and its row-dwell time pulse.
- Holds a double-buffered frame:
  - Producers write rows into a back buffer, then request a commit.
  - The back buffer is copied to the front (displayed) buffer only at a frame boundary, so the scanner never sees a half-updated image.
- Also generates the row-dwell tick that paces the scanner.

Parameters:
- TICK_DIV, 50000, clk cycles per row dwell (row_tick period); legal range >= 2.
- SCROLL_DIV, 16, frames between scroll steps; used only with MATRIX_SCROLL_EN; legal range >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- wr_en  in  1  write one row of the back buffer this cycle.
- wr_row  in  3  back-buffer row index; 0 = ROW1 (top).
- wr_data  in  8  row pixel data; bit7 = leftmost column.
- commit  in  1  single-cycle request to publish the back buffer at the next frame boundary.
- commit_pending  out  1  commit requested but not yet applied.
- frame_out  out  64  front buffer; ROW1=[63:56] … ROW8=[7:0]; drives the scanner frame input.
- row_tick  out  1  one-cycle pulse every TICK_DIV clks; drives the scanner time-pulse input.

Behaviour:
- Reset (rst==0 at posedge), all state forced:
  - frame_out = 64'hFFFF_FFFF_FFFF_FFFF (lamp test);
  - back buffer = all 0;
  - row_tick = 0; commit_pending = 0;
  - prescaler count, row count and scroll frame count = 0.
  - Reset mid-frame or mid-pending discards the pending commit.
- Prescaler:
  - cnt runs 0..TICK_DIV-1 and wraps.
  - row_tick is registered: high for exactly one cycle, on the cycle after cnt==TICK_DIV-1.
  - First pulse after reset release appears TICK_DIV cycles later.
- Row counter:
  - row_cnt (3 bits) increments on every row_tick and wraps 7->0.
  - Frame boundary = the cycle row_tick==1 and row_cnt==7.
- Writes:
  - wr_en writes back[wr_row] <= wr_data; row r maps to frame bits [63-8r : 56-8r].
  - Accepted every cycle, including while a commit is pending.
  - Back buffer persists after a swap; it is never auto-cleared.
- Commit:
  - commit==1 sets commit_pending next cycle.
  - Multiple commits before the boundary collapse into one.
- Swap, at a frame boundary with commit_pending==1:
  - front <= back, using back as it stood before that cycle's write.
  - A same-cycle write still lands in back but is not shown until the next commit.
  - commit_pending clears.
  - frame_out changes on the next cycle (1-cycle latency from boundary).
- Commit and swap in the same cycle: set wins; commit_pending stays 1 and a second swap occurs at the following boundary.
- No commit pending at a boundary: front unchanged.
- No combinational paths from inputs to outputs.

Optional Feature:
- Macro: MATRIX_SCROLL_EN.
- Defined:
  - A frame counter counts boundaries 0..SCROLL_DIV-1.
  - On the boundary where it wraps, every front row rotates left by one column: bit7 wraps to bit0.
  - If a swap occurs on that same boundary, the swap wins: the fresh frame loads unrotated, and the frame counter still wraps.
- Undefined: no frame counter; front changes only by swap; SCROLL_DIV ignored.

Decomposition:
- Package matrix_pkg:
  - ROWS=8, COLS=8, FRAME_W=64;
  - LAMP_TEST = 64'hFFFF_FFFF_FFFF_FFFF;
  - row-slice helper mapping a row index to its frame bit offset (63-8r MSB).
  - Shared with the scan controller.
- Sub-module: tick_prescaler (parameter TICK_DIV; ports clk, rst, tick) holds the divider; the top holds the buffers, row count, commit and scroll logic.

Test Plan:
- Reset check, TICK_DIV=4: hold rst=0 for 3 cycles, release -> frame_out=64'hFFFF_FFFF_FFFF_FFFF, commit_pending=0; first row_tick 4 cycles after release, then every 4 cycles, each 1 cycle wide.
- Basic publish: write rows 0..7 = 8'h81,8'h42,8'h24,8'h18,8'h18,8'h24,8'h42,8'h81, then commit -> commit_pending=1 until the 8th tick boundary; next cycle frame_out=64'h8142_2418_1824_4281, pending=0.
- Tear-free update: write row 0=8'hAA one cycle before the boundary and row 1=8'h55 on the boundary cycle -> frame_out[63:56]=8'hAA and [55:48] keeps its old value; a following commit shows 8'h55.
- Commit on the boundary cycle -> commit_pending remains 1; the swap repeats at the next boundary (frame_out unchanged if back unchanged), then pending=0.
- Mid-operation reset: commit pending, assert rst=0 for 1 cycle -> pending=0, frame_out=lamp test, back buffer=0; no swap at the next boundary.
- With MATRIX_SCROLL_EN, SCROLL_DIV=1, front row0=8'h80 -> after each boundary row0 = 8'h01, 8'h02, 8'h04…; commit in the same boundary loads back unrotated.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared geometry and helpers for the 8x8 LED matrix path (frame source and scan controller).
// ROW1 occupies the top byte of the frame; bit7 of each row is the leftmost column.
package matrix_pkg;
   localparam int ROWS    = 8;
   localparam int COLS    = 8;
   localparam int FRAME_W = ROWS * COLS;

   localparam logic [FRAME_W-1:0] LAMP_TEST = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef struct packed {
      logic       en;
      logic [2:0] row;
      logic [7:0] data;
   } rowWrite_t;

   // MSB of row r inside the frame: 63 - 8r
   function automatic logic [5:0] rowMsb(input logic [2:0] r);
      return 6'(FRAME_W - 1) - {r, 3'b000};
   endfunction
endpackage

// File: rtl/matrix_frame_source_tick_prescaler.sv
// Row-dwell divider: registered one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= (cnt == LAST);
         cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end
endmodule

// File: rtl/matrix_frame_source.sv
// Double-buffered frame feeder and row-dwell tick for the matrix scanner.
// Define MATRIX_SCROLL_EN to rotate the displayed image left every SCROLL_DIV frames.
module matrix_frame_source
   import matrix_pkg::*;
#(
   parameter int TICK_DIV   = 50000,
   parameter int SCROLL_DIV = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [2:0]  wr_row,
   input  logic [7:0]  wr_data,
   input  logic        commit,
   output logic        commit_pending,
   output logic [63:0] frame_out,
   output logic        row_tick
);
   logic               tick;
   logic [2:0]         rowCnt;
   logic               pending;
   logic               boundary;
   logic               swap;
   logic [FRAME_W-1:0] backBuf;
   logic [FRAME_W-1:0] frontBuf;
   rowWrite_t          wrReq;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) uPrescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign wrReq    = '{en: wr_en, row: wr_row, data: wr_data};
   assign boundary = tick && (rowCnt == 3'd7);
   assign swap     = boundary && pending;

   always_ff @(posedge clk) begin
      if (!rst)      rowCnt <= '0;
      else if (tick) rowCnt <= rowCnt + 3'd1;
   end

   // Back buffer is never cleared by a swap; producers may patch single rows.
   always_ff @(posedge clk) begin
      if (!rst)           backBuf <= '0;
      else if (wrReq.en)  backBuf[rowMsb(wrReq.row) -: COLS] <= wrReq.data;
   end

   // A fresh commit outranks the clear so a boundary-cycle commit is not lost.
   always_ff @(posedge clk) begin
      if (!rst)        pending <= 1'b0;
      else if (commit) pending <= 1'b1;
      else if (swap)   pending <= 1'b0;
   end

`ifdef MATRIX_SCROLL_EN
   localparam int FCW = $clog2(SCROLL_DIV + 1);
   localparam logic [FCW-1:0] FC_LAST = FCW'(SCROLL_DIV - 1);

   logic [FCW-1:0]     frameCnt;
   logic               scrollStep;
   logic [FRAME_W-1:0] rotated;

   assign scrollStep = boundary && (frameCnt == FC_LAST);

   for (genvar r = 0; r < ROWS; r++) begin : gRot
      assign rotated[8*r +: 8] = {frontBuf[8*r +: 7], frontBuf[8*r + 7]};
   end

   always_ff @(posedge clk) begin
      if (!rst)            frameCnt <= '0;
      else if (scrollStep) frameCnt <= '0;
      else if (boundary)   frameCnt <= frameCnt + FCW'(1);
   end

   // Swap beats scroll: a newly published frame always appears unrotated.
   always_ff @(posedge clk) begin
      if (!rst)            frontBuf <= LAMP_TEST;
      else if (swap)       frontBuf <= backBuf;
      else if (scrollStep) frontBuf <= rotated;
   end
`else
   always_ff @(posedge clk) begin
      if (!rst)      frontBuf <= LAMP_TEST;
      else if (swap) frontBuf <= backBuf;
   end
`endif

   assign frame_out      = frontBuf;
   assign commit_pending = pending;
   assign row_tick       = tick;
endmodule
